// File: rtl/multicycle_controller_pkg.sv
// Shared constants for the multi-cycle MIPS controller: opcode/funct values,
// FSM state encoding, ALU operation codes, mux encodings and the control bundle.
package multicycle_controller_pkg;

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // Funct codes (op = 0)
    localparam logic [5:0] FN_SLL     = 6'h00;
    localparam logic [5:0] FN_SRL     = 6'h02;
    localparam logic [5:0] FN_SRA     = 6'h03;
    localparam logic [5:0] FN_JR      = 6'h08;
    localparam logic [5:0] FN_SYSCALL = 6'h0C;
    localparam logic [5:0] FN_ADD     = 6'h20;
    localparam logic [5:0] FN_ADDU    = 6'h21;
    localparam logic [5:0] FN_SUB     = 6'h22;
    localparam logic [5:0] FN_SUBU    = 6'h23;
    localparam logic [5:0] FN_AND     = 6'h24;
    localparam logic [5:0] FN_OR      = 6'h25;
    localparam logic [5:0] FN_XOR     = 6'h26;
    localparam logic [5:0] FN_NOR     = 6'h27;
    localparam logic [5:0] FN_SLT     = 6'h2A;
    localparam logic [5:0] FN_SLTU    = 6'h2B;

    // FSM states
    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_EXEC_R   = 4'd2;
    localparam logic [3:0] S_EXEC_I   = 4'd3;
    localparam logic [3:0] S_WB_ALU   = 4'd4;
    localparam logic [3:0] S_MEM_ADDR = 4'd5;
    localparam logic [3:0] S_MEM_RD   = 4'd6;
    localparam logic [3:0] S_MEM_WR   = 4'd7;
    localparam logic [3:0] S_WB_LW    = 4'd8;
    localparam logic [3:0] S_BRANCH   = 4'd9;
    localparam logic [3:0] S_JUMP     = 4'd10;
    localparam logic [3:0] S_JR       = 4'd11;
    localparam logic [3:0] S_HALT     = 4'd12;

    // ALU operation codes
    localparam logic [3:0] ALU_ADD  = 4'h0;
    localparam logic [3:0] ALU_ADDU = 4'h1;
    localparam logic [3:0] ALU_SUB  = 4'h2;
    localparam logic [3:0] ALU_SUBU = 4'h3;
    localparam logic [3:0] ALU_AND  = 4'h4;
    localparam logic [3:0] ALU_OR   = 4'h5;
    localparam logic [3:0] ALU_XOR  = 4'h6;
    localparam logic [3:0] ALU_NOR  = 4'h7;
    localparam logic [3:0] ALU_SLT  = 4'h8;
    localparam logic [3:0] ALU_SLTU = 4'h9;
    localparam logic [3:0] ALU_SLL  = 4'hA;
    localparam logic [3:0] ALU_SRL  = 4'hB;
    localparam logic [3:0] ALU_SRA  = 4'hC;
    localparam logic [3:0] ALU_LUI  = 4'hD;

    // Datapath mux encodings
    localparam logic [1:0] PC_SRC_PLUS4  = 2'd0;
    localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
    localparam logic [1:0] PC_SRC_JUMP   = 2'd2;
    localparam logic [1:0] PC_SRC_RS     = 2'd3;
    localparam logic [1:0] REG_DST_RT    = 2'd0;
    localparam logic [1:0] REG_DST_RD    = 2'd1;
    localparam logic [1:0] REG_DST_R31   = 2'd2;
    localparam logic [1:0] WB_SRC_ALU    = 2'd0;
    localparam logic [1:0] WB_SRC_MEM    = 2'd1;
    localparam logic [1:0] WB_SRC_PC4    = 2'd2;

    typedef enum logic [3:0] {
        CLS_R_ALU, CLS_I_ALU, CLS_LW, CLS_SW, CLS_BEQ, CLS_BNE,
        CLS_J, CLS_JAL, CLS_JR, CLS_SYSCALL, CLS_ILLEGAL
    } instr_class_e;

    // One cycle's worth of datapath control strobes
    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       mem_addr_src;
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_src;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] wb_src;
        logic       alu_src_b;
        logic       ext_sign;
        logic [3:0] alu_op;
        logic       illegal;
        logic       mem_err;
        logic       halted;
    } ctrl_t;

endpackage

// File: rtl/multicycle_controller_instr_classifier.sv
// Combinational op/funct decoder: instruction class, ALU operation and
// immediate extension mode, so the FSM never looks at raw opcode values.
module instr_classifier
    import multicycle_controller_pkg::*;
(
    input  logic [5:0]   op,
    input  logic [5:0]   funct,
    output instr_class_e cls,
    output logic [3:0]   alu_op,
    output logic         ext_sign,
    output logic         illegal
);

    // Opcode/funct lookup; anything not listed stays CLS_ILLEGAL
    always_comb begin
        cls      = CLS_ILLEGAL;
        alu_op   = ALU_ADD;
        ext_sign = 1'b0;
        case (op)
            OP_RTYPE: begin
                cls = CLS_R_ALU;
                case (funct)
                    FN_ADD:     alu_op = ALU_ADD;
                    FN_ADDU:    alu_op = ALU_ADDU;
                    FN_SUB:     alu_op = ALU_SUB;
                    FN_SUBU:    alu_op = ALU_SUBU;
                    FN_AND:     alu_op = ALU_AND;
                    FN_OR:      alu_op = ALU_OR;
                    FN_XOR:     alu_op = ALU_XOR;
                    FN_NOR:     alu_op = ALU_NOR;
                    FN_SLT:     alu_op = ALU_SLT;
                    FN_SLTU:    alu_op = ALU_SLTU;
                    FN_SLL:     alu_op = ALU_SLL;
                    FN_SRL:     alu_op = ALU_SRL;
                    FN_SRA:     alu_op = ALU_SRA;
                    FN_JR:      cls = CLS_JR;
                    FN_SYSCALL: cls = CLS_SYSCALL;
                    default:    cls = CLS_ILLEGAL;
                endcase
            end
            OP_ADDI:  begin cls = CLS_I_ALU; alu_op = ALU_ADD;  ext_sign = 1'b1; end
            OP_ADDIU: begin cls = CLS_I_ALU; alu_op = ALU_ADDU; ext_sign = 1'b1; end
            OP_SLTI:  begin cls = CLS_I_ALU; alu_op = ALU_SLT;  ext_sign = 1'b1; end
            OP_SLTIU: begin cls = CLS_I_ALU; alu_op = ALU_SLTU; ext_sign = 1'b1; end
            OP_ANDI:  begin cls = CLS_I_ALU; alu_op = ALU_AND; end
            OP_ORI:   begin cls = CLS_I_ALU; alu_op = ALU_OR;  end
            OP_XORI:  begin cls = CLS_I_ALU; alu_op = ALU_XOR; end
            OP_LUI:   begin cls = CLS_I_ALU; alu_op = ALU_LUI; end
            OP_LW:    cls = CLS_LW;
            OP_SW:    cls = CLS_SW;
            OP_BEQ:   cls = CLS_BEQ;
            OP_BNE:   cls = CLS_BNE;
            OP_J:     cls = CLS_J;
            OP_JAL:   cls = CLS_JAL;
            default:  cls = CLS_ILLEGAL;
        endcase
    end

    assign illegal = (cls == CLS_ILLEGAL);

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS control FSM. State is registered; every strobe is a
// combinational function of the state, the current IR fields, zero and mem_ready.
module multicycle_controller
    import multicycle_controller_pkg::*;
#(
    parameter int MEM_TIMEOUT = 0
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       mem_addr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       reg_write,
    output logic [1:0] reg_dst,
    output logic [1:0] wb_src,
    output logic       alu_src_b,
    output logic       ext_sign,
    output logic [3:0] alu_op,
    output logic       illegal,
    output logic       mem_err,
    output logic       halted
);

    logic [3:0]   state_q, state_d;
    ctrl_t        ctrl;
    instr_class_e cls;
    logic [3:0]   cls_alu_op;
    logic         cls_ext_sign;
    logic         cls_illegal;
    logic         timeout;

    instr_classifier u_classifier (
        .op       (op),
        .funct    (funct),
        .cls      (cls),
        .alu_op   (cls_alu_op),
        .ext_sign (cls_ext_sign),
        .illegal  (cls_illegal)
    );

    generate
        if (MEM_TIMEOUT > 0) begin : g_timeout
            localparam int CW = $clog2(MEM_TIMEOUT + 1);
            logic [CW-1:0] wait_cnt_q, wait_cnt_d;
            logic          in_mem_state;

            assign in_mem_state = (state_q == S_FETCH) || (state_q == S_MEM_RD) ||
                                  (state_q == S_MEM_WR);
            // The cycle after MEM_TIMEOUT unanswered requests is the error cycle
            assign timeout = in_mem_state && (wait_cnt_q == CW'(MEM_TIMEOUT));

            // Count consecutive wait cycles; any exit or re-entry starts from zero
            always_comb begin
                wait_cnt_d = '0;
                if (in_mem_state && !mem_ready && !timeout) begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end

            // Wait counter register
            always_ff @(posedge clk) begin
                if (rst) begin
                    wait_cnt_q <= '0;
                end else begin
                    wait_cnt_q <= wait_cnt_d;
                end
            end
        end else begin : g_no_timeout
            assign timeout = 1'b0;
        end
    endgenerate

    // Next-state and control strobe decode; reset forces everything quiet
    always_comb begin
        state_d = state_q;
        ctrl    = '0;
        case (state_q)
            S_FETCH: begin
                if (timeout) begin
                    ctrl.mem_err = 1'b1;          // retry the same PC next cycle
                end else begin
                    ctrl.mem_req = 1'b1;
                    if (mem_ready) begin
                        ctrl.ir_write = 1'b1;
                        ctrl.pc_write = 1'b1;
                        ctrl.pc_src   = PC_SRC_PLUS4;
                        state_d       = S_DECODE;
                    end
                end
            end
            S_DECODE: begin
                case (cls)
                    CLS_R_ALU:       state_d = S_EXEC_R;
                    CLS_I_ALU:       state_d = S_EXEC_I;
                    CLS_LW, CLS_SW:  state_d = S_MEM_ADDR;
                    CLS_BEQ, CLS_BNE: state_d = S_BRANCH;
                    CLS_J, CLS_JAL:  state_d = S_JUMP;
                    CLS_JR:          state_d = S_JR;
                    CLS_SYSCALL:     state_d = S_HALT;
                    default: begin
                        ctrl.illegal = cls_illegal;
                        state_d      = S_FETCH;
                    end
                endcase
            end
            S_EXEC_R: begin
                ctrl.alu_op = cls_alu_op;
                state_d     = S_WB_ALU;
            end
            S_EXEC_I: begin
                ctrl.alu_src_b = 1'b1;
                ctrl.ext_sign  = cls_ext_sign;
                ctrl.alu_op    = cls_alu_op;
                state_d        = S_WB_ALU;
            end
            S_WB_ALU: begin
                ctrl.reg_write = 1'b1;
                ctrl.wb_src    = WB_SRC_ALU;
                ctrl.reg_dst   = (cls == CLS_R_ALU) ? REG_DST_RD : REG_DST_RT;
                state_d        = S_FETCH;
            end
            S_MEM_ADDR: begin
                ctrl.alu_op    = ALU_ADD;
                ctrl.alu_src_b = 1'b1;
                ctrl.ext_sign  = 1'b1;
                state_d        = (cls == CLS_SW) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD, S_MEM_WR: begin
                if (timeout) begin
                    ctrl.mem_err = 1'b1;
                    state_d      = S_FETCH;
                end else begin
                    ctrl.mem_req      = 1'b1;
                    ctrl.mem_addr_src = 1'b1;
                    ctrl.mem_we       = (state_q == S_MEM_WR);
                    if (mem_ready) begin
                        state_d = (state_q == S_MEM_WR) ? S_FETCH : S_WB_LW;
                    end
                end
            end
            S_WB_LW: begin
                ctrl.reg_write = 1'b1;
                ctrl.wb_src    = WB_SRC_MEM;
                ctrl.reg_dst   = REG_DST_RT;
                state_d        = S_FETCH;
            end
            S_BRANCH: begin
                ctrl.alu_op   = ALU_SUB;
                ctrl.pc_src   = PC_SRC_BRANCH;
                ctrl.pc_write = ((cls == CLS_BEQ) && zero) || ((cls == CLS_BNE) && !zero);
                state_d       = S_FETCH;
            end
            S_JUMP: begin
                ctrl.pc_write = 1'b1;
                ctrl.pc_src   = PC_SRC_JUMP;
                if (cls == CLS_JAL) begin
                    ctrl.reg_write = 1'b1;
                    ctrl.reg_dst   = REG_DST_R31;
                    ctrl.wb_src    = WB_SRC_PC4;
                end
                state_d = S_FETCH;
            end
            S_JR: begin
                ctrl.pc_write = 1'b1;
                ctrl.pc_src   = PC_SRC_RS;
                state_d       = S_FETCH;
            end
            S_HALT: begin
                ctrl.halted = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
        if (rst) begin
            ctrl    = '0;
            state_d = S_FETCH;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    assign mem_req      = ctrl.mem_req;
    assign mem_we       = ctrl.mem_we;
    assign mem_addr_src = ctrl.mem_addr_src;
    assign ir_write     = ctrl.ir_write;
    assign pc_write     = ctrl.pc_write;
    assign pc_src       = ctrl.pc_src;
    assign reg_write    = ctrl.reg_write;
    assign reg_dst      = ctrl.reg_dst;
    assign wb_src       = ctrl.wb_src;
    assign alu_src_b    = ctrl.alu_src_b;
    assign ext_sign     = ctrl.ext_sign;
    assign alu_op       = ctrl.alu_op;
    assign illegal      = ctrl.illegal;
    assign mem_err      = ctrl.mem_err;
    assign halted       = ctrl.halted;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: each stimulus cycle pushes the
// expected strobe bundle; a negedge monitor pops and compares it.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] op = '0;
    logic [5:0] funct = '0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req, mem_we, mem_addr_src, ir_write, pc_write;
    logic [1:0] pc_src, reg_dst, wb_src;
    logic       reg_write, alu_src_b, ext_sign, illegal, mem_err, halted;
    logic [3:0] alu_op;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       mem_addr_src;
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_src;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] wb_src;
        logic       alu_src_b;
        logic       ext_sign;
        logic [3:0] alu_op;
        logic       illegal;
        logic       mem_err;
        logic       halted;
    } obs_t;

    obs_t  act;
    obs_t  exp_q[$];
    string name_q[$];
    obs_t  mon_exp;
    string mon_name;
    int    n_checks = 0;
    int    n_pass = 0;

    always #5 clk = ~clk;

    multicycle_controller #(.MEM_TIMEOUT(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .op           (op),
        .funct        (funct),
        .zero         (zero),
        .mem_ready    (mem_ready),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr_src (mem_addr_src),
        .ir_write     (ir_write),
        .pc_write     (pc_write),
        .pc_src       (pc_src),
        .reg_write    (reg_write),
        .reg_dst      (reg_dst),
        .wb_src       (wb_src),
        .alu_src_b    (alu_src_b),
        .ext_sign     (ext_sign),
        .alu_op       (alu_op),
        .illegal      (illegal),
        .mem_err      (mem_err),
        .halted       (halted)
    );

    assign act = {mem_req, mem_we, mem_addr_src, ir_write, pc_write, pc_src,
                  reg_write, reg_dst, wb_src, alu_src_b, ext_sign, alu_op,
                  illegal, mem_err, halted};

    // Expected strobe bundles for each kind of cycle
    function automatic obs_t e_quiet();
        return '0;
    endfunction
    function automatic obs_t e_fetch(input logic rdy);
        obs_t o = '0;
        o.mem_req = 1'b1; o.ir_write = rdy; o.pc_write = rdy;
        return o;
    endfunction
    function automatic obs_t e_ill();
        obs_t o = '0;
        o.illegal = 1'b1;
        return o;
    endfunction
    function automatic obs_t e_exec_r(input logic [3:0] aop);
        obs_t o = '0;
        o.alu_op = aop;
        return o;
    endfunction
    function automatic obs_t e_exec_i(input logic [3:0] aop, input logic ext);
        obs_t o = '0;
        o.alu_src_b = 1'b1; o.ext_sign = ext; o.alu_op = aop;
        return o;
    endfunction
    function automatic obs_t e_wb_alu(input logic [1:0] dst);
        obs_t o = '0;
        o.reg_write = 1'b1; o.reg_dst = dst;
        return o;
    endfunction
    function automatic obs_t e_mem_addr();
        obs_t o = '0;
        o.alu_src_b = 1'b1; o.ext_sign = 1'b1; o.alu_op = 4'h0;
        return o;
    endfunction
    function automatic obs_t e_mem(input logic we);
        obs_t o = '0;
        o.mem_req = 1'b1; o.mem_addr_src = 1'b1; o.mem_we = we;
        return o;
    endfunction
    function automatic obs_t e_wb_lw();
        obs_t o = '0;
        o.reg_write = 1'b1; o.wb_src = 2'd1; o.reg_dst = 2'd0;
        return o;
    endfunction
    function automatic obs_t e_branch(input logic taken);
        obs_t o = '0;
        o.alu_op = 4'h2; o.pc_src = 2'd1; o.pc_write = taken;
        return o;
    endfunction
    function automatic obs_t e_jump(input logic link);
        obs_t o = '0;
        o.pc_write = 1'b1; o.pc_src = 2'd2;
        if (link) begin
            o.reg_write = 1'b1; o.reg_dst = 2'd2; o.wb_src = 2'd2;
        end
        return o;
    endfunction
    function automatic obs_t e_jr();
        obs_t o = '0;
        o.pc_write = 1'b1; o.pc_src = 2'd3;
        return o;
    endfunction
    function automatic obs_t e_halt();
        obs_t o = '0;
        o.halted = 1'b1;
        return o;
    endfunction
    function automatic obs_t e_err();
        obs_t o = '0;
        o.mem_err = 1'b1;
        return o;
    endfunction

    // Drive one cycle of inputs and queue the strobes expected in that cycle
    task automatic step(input logic r, input logic [5:0] o, input logic [5:0] f,
                        input logic z, input logic rdy, input obs_t e, input string n);
        rst = r; op = o; funct = f; zero = z; mem_ready = rdy;
        exp_q.push_back(e);
        name_q.push_back(n);
        @(posedge clk);
        #1;
    endtask

    task automatic txn(input string n);
        $display("[%0t] txn %s", $time, n);
    endtask

    // Four-cycle ALU instruction with zero memory wait
    task automatic alu_instr(input logic [5:0] o, input logic [5:0] f, input obs_t ex,
                             input logic [1:0] dst, input string n);
        txn(n);
        step(0, o, f, 0, 1, e_fetch(1), {n, " fetch"});
        step(0, o, f, 0, 1, e_quiet(), {n, " decode"});
        step(0, o, f, 0, 1, ex, {n, " exec"});
        step(0, o, f, 0, 1, e_wb_alu(dst), {n, " wb"});
    endtask

    // Monitor: compare DUT strobes against the scoreboard on the falling edge
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_exp  = exp_q.pop_front();
            mon_name = name_q.pop_front();
            n_checks++;
            if (act !== mon_exp) begin
                $display("FAIL %s: got %h required %h", mon_name, act, mon_exp);
            end else begin
                n_pass++;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge clk);
        #1;
        txn("reset");
        step(1, 6'h00, 6'h20, 0, 1, e_quiet(), "reset c0");
        step(1, 6'h00, 6'h20, 0, 1, e_quiet(), "reset c1");

        alu_instr(6'h00, 6'h20, e_exec_r(4'h0), 2'd1, "add");
        alu_instr(6'h00, 6'h03, e_exec_r(4'hC), 2'd1, "sra");
        alu_instr(6'h00, 6'h27, e_exec_r(4'h7), 2'd1, "nor");
        alu_instr(6'h08, 6'h00, e_exec_i(4'h0, 1'b1), 2'd0, "addi");
        alu_instr(6'h0D, 6'h00, e_exec_i(4'h5, 1'b0), 2'd0, "ori");
        alu_instr(6'h0B, 6'h00, e_exec_i(4'h9, 1'b1), 2'd0, "sltiu");

        txn("lw with 2 wait cycles");
        step(0, 6'h23, 0, 0, 1, e_fetch(1), "lw fetch");
        step(0, 6'h23, 0, 0, 0, e_quiet(), "lw decode");
        step(0, 6'h23, 0, 0, 1, e_mem_addr(), "lw addr");
        step(0, 6'h23, 0, 0, 0, e_mem(0), "lw rd wait1");
        step(0, 6'h23, 0, 0, 0, e_mem(0), "lw rd wait2");
        step(0, 6'h23, 0, 0, 1, e_mem(0), "lw rd done");
        step(0, 6'h23, 0, 0, 1, e_wb_lw(), "lw wb");

        txn("sw");
        step(0, 6'h2B, 0, 0, 1, e_fetch(1), "sw fetch");
        step(0, 6'h2B, 0, 0, 1, e_quiet(), "sw decode");
        step(0, 6'h2B, 0, 0, 1, e_mem_addr(), "sw addr");
        step(0, 6'h2B, 0, 0, 1, e_mem(1), "sw wr");

        txn("beq zero=1");
        step(0, 6'h04, 0, 1, 1, e_fetch(1), "beq fetch");
        step(0, 6'h04, 0, 1, 1, e_quiet(), "beq decode");
        step(0, 6'h04, 0, 1, 1, e_branch(1), "beq taken");
        txn("bne zero=1");
        step(0, 6'h05, 0, 1, 1, e_fetch(1), "bne fetch");
        step(0, 6'h05, 0, 1, 1, e_quiet(), "bne decode");
        step(0, 6'h05, 0, 1, 1, e_branch(0), "bne not taken");
        txn("bne zero=0");
        step(0, 6'h05, 0, 0, 1, e_fetch(1), "bne2 fetch");
        step(0, 6'h05, 0, 0, 1, e_quiet(), "bne2 decode");
        step(0, 6'h05, 0, 0, 1, e_branch(1), "bne2 taken");

        txn("j");
        step(0, 6'h02, 0, 0, 1, e_fetch(1), "j fetch");
        step(0, 6'h02, 0, 0, 1, e_quiet(), "j decode");
        step(0, 6'h02, 0, 0, 1, e_jump(0), "j jump");
        txn("jal");
        step(0, 6'h03, 0, 0, 1, e_fetch(1), "jal fetch");
        step(0, 6'h03, 0, 0, 1, e_quiet(), "jal decode");
        step(0, 6'h03, 0, 0, 1, e_jump(1), "jal jump");
        txn("jr");
        step(0, 6'h00, 6'h08, 0, 1, e_fetch(1), "jr fetch");
        step(0, 6'h00, 6'h08, 0, 1, e_quiet(), "jr decode");
        step(0, 6'h00, 6'h08, 0, 1, e_jr(), "jr exec");

        txn("illegal op 0x3F");
        step(0, 6'h3F, 0, 0, 1, e_fetch(1), "ill op fetch");
        step(0, 6'h3F, 0, 0, 1, e_ill(), "ill op decode");
        txn("illegal funct 0x01");
        step(0, 6'h00, 6'h01, 0, 1, e_fetch(1), "ill fn fetch");
        step(0, 6'h00, 6'h01, 0, 1, e_ill(), "ill fn decode");

        txn("slt with 2 fetch waits");
        step(0, 6'h00, 6'h2A, 0, 0, e_fetch(0), "slt fetch wait1");
        step(0, 6'h00, 6'h2A, 0, 0, e_fetch(0), "slt fetch wait2");
        step(0, 6'h00, 6'h2A, 0, 1, e_fetch(1), "slt fetch");
        step(0, 6'h00, 6'h2A, 0, 1, e_quiet(), "slt decode");
        step(0, 6'h00, 6'h2A, 0, 1, e_exec_r(4'h8), "slt exec");
        step(0, 6'h00, 6'h2A, 0, 1, e_wb_alu(2'd1), "slt wb");

        txn("fetch timeout");
        for (int i = 0; i < 4; i++) begin
            step(0, 6'h00, 6'h22, 0, 0, e_fetch(0), "timeout wait");
        end
        step(0, 6'h00, 6'h22, 0, 0, e_err(), "timeout mem_err");
        step(0, 6'h00, 6'h22, 0, 0, e_fetch(0), "retry wait");
        step(0, 6'h00, 6'h22, 0, 1, e_fetch(1), "retry fetch");
        step(0, 6'h00, 6'h22, 0, 1, e_quiet(), "sub decode");
        step(0, 6'h00, 6'h22, 0, 1, e_exec_r(4'h2), "sub exec");
        step(0, 6'h00, 6'h22, 0, 1, e_wb_alu(2'd1), "sub wb");

        txn("reset during lw memory wait");
        step(0, 6'h23, 0, 0, 1, e_fetch(1), "lwr fetch");
        step(0, 6'h23, 0, 0, 1, e_quiet(), "lwr decode");
        step(0, 6'h23, 0, 0, 1, e_mem_addr(), "lwr addr");
        step(0, 6'h23, 0, 0, 0, e_mem(0), "lwr rd wait");
        for (int i = 0; i < 3; i++) begin
            step(1, 6'h23, 0, 0, 1, e_quiet(), "lwr in reset");
        end
        step(0, 6'h23, 0, 0, 0, e_fetch(0), "post-reset fetch");
        step(0, 6'h23, 0, 0, 1, e_fetch(1), "lwr2 fetch");
        step(0, 6'h23, 0, 0, 1, e_quiet(), "lwr2 decode");
        step(0, 6'h23, 0, 0, 1, e_mem_addr(), "lwr2 addr");
        step(0, 6'h23, 0, 0, 1, e_mem(0), "lwr2 rd");
        step(0, 6'h23, 0, 0, 1, e_wb_lw(), "lwr2 wb");

        txn("syscall");
        step(0, 6'h00, 6'h0C, 0, 1, e_fetch(1), "sys fetch");
        step(0, 6'h00, 6'h0C, 0, 1, e_quiet(), "sys decode");
        for (int i = 0; i < 20; i++) begin
            step(0, 6'h00, 6'h0C, 0, i[0], e_halt(), "halted");
        end
        txn("reset out of halt");
        step(1, 6'h00, 6'h0C, 0, 1, e_quiet(), "halt reset");
        step(0, 6'h00, 6'h20, 0, 1, e_fetch(1), "after halt fetch");

        // Scoreboard must be fully drained by the monitor
        for (int i = 0; i < 4 && exp_q.size() != 0; i++) begin
            @(negedge clk);
        end
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            $display("FAIL scoreboard drain: got %0d entries left required 0", exp_q.size());
        end else begin
            n_pass++;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
